// File: rtl/dll_dly_ctrl.sv
// DLL delay-code controller: filters early/late phase-detector votes and
// steps a 6-bit {coarse,fine} delay code, flagging lock and saturation.
//
// Ports:
//   i_clk, i_rstn         clock, async active-low reset
//   i_en                  loop enable (0 = hold code, clear filter/lock/errors)
//   i_pd_valid, i_pd_up   phase-detector strobe and direction (1 = more delay)
//   o_sel_coarse [2:0]    code[5:3]
//   o_sel_fine   [2:0]    code[2:0]
//   o_lock                dithering around one code
//   o_max_err, o_min_err  sticky: step blocked at code 63 / code 0
module dll_dly_ctrl #(
   parameter int FILT_N     = 4,
   parameter int SETTLE_CYC = 4,
   parameter int LOCK_CNT   = 4
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_en,
   input  logic       i_pd_valid,
   input  logic       i_pd_up,
   output logic [2:0] o_sel_coarse,
   output logic [2:0] o_sel_fine,
   output logic       o_lock,
   output logic       o_max_err,
   output logic       o_min_err
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE
   } state_t;

   localparam logic signed [4:0] FILT_P   = 5'(FILT_N);
   localparam logic signed [4:0] FILT_M   = -FILT_P;
   localparam logic        [3:0] SETTLE_L = 4'(SETTLE_CYC);
   localparam logic        [3:0] LOCK_L   = 4'(LOCK_CNT);

   state_t            state_q, state_d;
   logic [5:0]        code_q, code_d;
   logic signed [4:0] acc_q, acc_d;
   logic signed [4:0] acc_inc;
   logic [3:0]        settle_q, settle_d;
   logic [3:0]        rev_q, rev_d;
   logic              last_up_q, last_up_d;
   logic              lock_q, lock_d;
   logic              max_q, max_d;
   logic              min_q, min_d;
   logic              dec;

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      acc_d     = acc_q;
      settle_d  = settle_q;
      rev_d     = rev_q;
      last_up_d = last_up_q;
      lock_d    = lock_q;
      max_d     = max_q;
      min_d     = min_q;
      dec       = 1'b0;
      acc_inc   = i_pd_up ? acc_q + 5'sd1 : acc_q - 5'sd1;

      if (!i_en) begin
         state_d  = IDLE;
         acc_d    = '0;
         settle_d = '0;
         rev_d    = '0;
         lock_d   = 1'b0;
         max_d    = 1'b0;
         min_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d  = SETTLE;
               settle_d = SETTLE_L;
            end
            SETTLE: begin
               settle_d = settle_q - 4'd1;
               if (settle_q <= 4'd1) begin
                  settle_d = '0;
                  state_d  = SAMPLE;
               end
            end
            SAMPLE: begin
               if (i_pd_valid) begin
                  acc_d = acc_inc;
                  if (acc_inc == FILT_P || acc_inc == FILT_M) begin
                     dec      = 1'b1;
                     acc_d    = '0;
                     state_d  = SETTLE;
                     settle_d = SETTLE_L;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Blocked steps at the range ends still count for lock tracking.
      if (dec) begin
         last_up_d = i_pd_up;
         if (i_pd_up != last_up_q) begin
            rev_d = (rev_q >= LOCK_L) ? LOCK_L : rev_q + 4'd1;
            if (rev_d == LOCK_L) lock_d = 1'b1;
         end else begin
            rev_d  = '0;
            lock_d = 1'b0;
         end
         if (i_pd_up) begin
            if (code_q == 6'd63) begin
               max_d = 1'b1;
            end else begin
               code_d = code_q + 6'd1;
               min_d  = 1'b0;
            end
         end else begin
            if (code_q == 6'd0) begin
               min_d = 1'b1;
            end else begin
               code_d = code_q - 6'd1;
               max_d  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= IDLE;
         code_q    <= '0;
         acc_q     <= '0;
         settle_q  <= '0;
         rev_q     <= '0;
         last_up_q <= 1'b1;
         lock_q    <= 1'b0;
         max_q     <= 1'b0;
         min_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         acc_q     <= acc_d;
         settle_q  <= settle_d;
         rev_q     <= rev_d;
         last_up_q <= last_up_d;
         lock_q    <= lock_d;
         max_q     <= max_d;
         min_q     <= min_d;
      end
   end

   assign o_sel_coarse = code_q[5:3];
   assign o_sel_fine   = code_q[2:0];
   assign o_lock       = lock_q;
   assign o_max_err    = max_q;
   assign o_min_err    = min_q;

endmodule
